// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider. It performs one shift-and-subtract step per falling clock edge
// and is driven through a start/busy/done handshake.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] count_r;

    // The trial value is one bit wider than the remainder, so the compare cannot overflow.
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;
    logic             fits_s;
    logic             last_s;
    logic             zero_s;

    // One restoring step: shift in the next dividend bit, then subtract if the divisor fits.
    always_comb begin
        trial_s = {rem_r, quo_r[WIDTH-1]};
        fits_s  = (trial_s >= {1'b0, dvs_r});
        if (fits_s) begin
            rem_step_s = WIDTH'(trial_s - {1'b0, dvs_r});
        end else begin
            rem_step_s = trial_s[WIDTH-1:0];
        end
        quo_step_s = {quo_r[WIDTH-2:0], fits_s};
        last_s     = (count_r == LAST_CNT);
        zero_s     = (divisor == {WIDTH{1'b0}});
    end

    // Next-state logic for the control FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = zero_s ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, plus the busy/done flags registered from the next state.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != ST_IDLE);
            done    <= (state_nxt_s == ST_DONE);
        end
    end

    // Datapath: operand capture, iteration, and the result registers.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            dvs_r     <= {WIDTH{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            quotient  <= {WIDTH{1'b0}};
            remainder <= {WIDTH{1'b0}};
            div_zero  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        dvs_r    <= divisor;
                        quo_r    <= dividend;
                        rem_r    <= {WIDTH{1'b0}};
                        count_r  <= {CNT_W{1'b0}};
                        div_zero <= zero_s;
                        // A zero divisor completes immediately with the conventional all-ones quotient.
                        if (zero_s) begin
                            quotient  <= {WIDTH{1'b1}};
                            remainder <= dividend;
                        end
                    end
                end
                ST_RUN: begin
                    rem_r   <= rem_step_s;
                    quo_r   <= quo_step_s;
                    count_r <= count_r + CNT_W'(1);
                    if (last_s) begin
                        quotient  <= quo_step_s;
                        remainder <= rem_step_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer. An arithmetic reference model is compared against the
// outputs on every rising edge, with directed literal checks on top.
module tb_div_sequencer;
    localparam int W = 32;

    logic         clk = 1'b1;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_left is the number of falling edges remaining until the unit is idle again.
    int           m_left = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_dz = 1'b0;
    int           edge_n = 0;
    int           acc_edges[$];

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_q    <= '0;
            m_r    <= '0;
            m_dz   <= 1'b0;
        end else begin
            edge_n <= edge_n + 1;
            if (m_left == 0) begin
                if (start) begin
                    acc_edges.push_back(edge_n);
                    if (divisor == '0) begin
                        m_left <= 1;
                        m_q    <= '1;
                        m_r    <= dividend;
                        m_dz   <= 1'b1;
                    end else begin
                        m_left <= W + 1;
                        p_q    <= dividend / divisor;
                        p_r    <= dividend % divisor;
                        m_dz   <= 1'b0;
                    end
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 2) begin
                    m_q <= p_q;
                    m_r <= p_r;
                end
            end
        end
    end

    // Compare process: checks all outputs against the model on every rising edge.
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    always @(posedge clk) begin
        chk("busy", W'(busy), W'(m_left != 0));
        chk("done", W'(done), W'(m_left == 1));
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
        chk("div_zero", W'(div_zero), W'(m_dz));
        if (done) begin
            chk("done_consecutive", W'(prev_done), W'(0));
            done_cnt <= done_cnt + 1;
        end
        prev_done <= done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the number of edges from acceptance to the edge that raised done, or -1 on timeout.
    task automatic wait_done(output int lat);
        bit found;
        found = 1'b0;
        lat   = -1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                found = 1'b1;
                lat   = edge_n - 1 - acc_edges[$];
            end
        end
        if (!found) chk("done_timeout", W'(0), W'(1));
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input int elat, input string tag);
        int lat;
        issue(a, b);
        wait_done(lat);
        chk({tag, "_lat"}, W'(lat), W'(elat));
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, W'(div_zero), W'(edz));
    endtask

    initial begin
        int lat;
        int dc0;
        int na;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_q", quotient, W'(0));
        chk("rst_r", remainder, W'(0));
        chk("rst_dz", W'(div_zero), W'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic case and extremes.
        dc0 = done_cnt;
        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W, "basic");
        repeat (3) @(posedge clk);
        chk("basic_one_done", W'(done_cnt - dc0), W'(1));
        run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, W, "max_div1");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, W, "max_divmax");
        run_op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, W, "small");

        // Divide by zero completes right after acceptance; the next divide clears div_zero.
        run_op(32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 0, "dz");
        run_op(32'd10, 32'd3, 32'd3, 32'd1, 1'b0, W, "after_dz");

        // A start pulse while busy is ignored, and so are the changed operands.
        @(posedge clk);
        dc0 = done_cnt;
        issue(32'd100, 32'd7);
        repeat (4) @(negedge clk);
        #1;
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("busy_start_lat", W'(lat), W'(W));
        chk("busy_start_q", quotient, 32'd14);
        chk("busy_start_r", remainder, 32'd2);
        repeat (40) @(posedge clk);
        chk("busy_start_one_done", W'(done_cnt - dc0), W'(1));

        // Reset in the middle of an operation aborts it without a done pulse.
        dc0 = done_cnt;
        issue(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        chk("midrst_q", quotient, W'(0));
        chk("midrst_r", remainder, W'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        chk("midrst_no_done", W'(done_cnt - dc0), W'(0));
        run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, W, "after_rst");

        // Back-to-back: start held high.
        @(posedge clk);
        na       = acc_edges.size();
        #1;
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        repeat (110) @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 60 && busy; i++) @(posedge clk);
        #1;
        chk("b2b_count_ge3", W'(acc_edges.size() - na >= 3), W'(1));
        for (int i = na + 1; i < acc_edges.size(); i++)
            chk("b2b_spacing", W'(acc_edges[i] - acc_edges[i-1]), W'(W + 2));
        chk("b2b_q", quotient, 32'd10);
        chk("b2b_r", remainder, 32'd0);

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            start    = ($urandom_range(0, 3) == 0);
            dividend = $urandom;
            case ($urandom_range(0, 7))
                0:       divisor = '0;
                1:       divisor = W'($urandom_range(1, 15));
                2:       divisor = dividend >> $urandom_range(0, 31);
                default: divisor = $urandom;
            endcase
        end
        start = 1'b0;
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
